// File: rtl/common_pkg.sv
// -----------------------------------------------------------------------------
// common_pkg
//
// Purpose : constants shared by the pipeline shadow-register blocks.
// Contents: RV_NOP   - canonical RV32I no-op (addi x0, x0, 0), used as the
//                      default bubble word so a flushed or bubbled stage
//                      decodes as a harmless instruction.
//           RV_INSN_W - width of an RV32I instruction word.
// -----------------------------------------------------------------------------
package common_pkg;

  localparam int unsigned RV_INSN_W = 32;
  localparam logic [RV_INSN_W-1:0] RV_NOP = 32'h0000_0013;

endpackage : common_pkg

// File: rtl/pipe_stage.sv
// -----------------------------------------------------------------------------
// pipe_stage
//
// Purpose : one register slot of the delay line. Holds a data word plus a
//           valid bit and updates them on each enabled rising edge according to
//           a fixed priority: flush > hold > bubble > advance.
//
// Ports   : i_clk        clock, rising edge
//           i_reset      asynchronous active-high reset
//           i_enable     global advance gate; low freezes the stage
//           i_prev_data  word offered by the younger neighbour (or line input)
//           i_prev_valid valid bit offered by the younger neighbour
//           i_flush      kill this stage (write bubble, clear valid)
//           i_hold       keep the current content (effective hold)
//           i_bubble     younger neighbour is held: insert a bubble here
//           o_data       registered stage word
//           o_valid      registered stage valid
//           o_valid_d    next-state valid, used for the registered occupancy
//                        count so that it lines up with o_valid
// -----------------------------------------------------------------------------
module pipe_stage #(
  parameter int unsigned        DATA_W     = 32,
  parameter logic [DATA_W-1:0]  RESET_VAL  = '0,
  parameter logic [DATA_W-1:0]  BUBBLE_VAL = '0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic [DATA_W-1:0] i_prev_data,
  input  logic              i_prev_valid,
  input  logic              i_flush,
  input  logic              i_hold,
  input  logic              i_bubble,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_valid_d
);

  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;
  logic              valid_q;
  logic              valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (i_enable) begin
      if (i_flush) begin
        // Flush wins even when the stage is also held.
        data_d  = BUBBLE_VAL;
        valid_d = 1'b0;
      end else if (i_hold) begin
        data_d  = data_q;
        valid_d = valid_q;
      end else if (i_bubble) begin
        // The younger stage is frozen, so nothing moves into this slot.
        data_d  = BUBBLE_VAL;
        valid_d = 1'b0;
      end else begin
        // Invalid words still carry their data through unchanged.
        data_d  = i_prev_data;
        valid_d = i_prev_valid;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      data_q  <= RESET_VAL;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign o_data    = data_q;
  assign o_valid   = valid_q;
  assign o_valid_d = valid_d;

endmodule : pipe_stage

// File: rtl/pipe_delay_line.sv
// -----------------------------------------------------------------------------
// pipe_delay_line
//
// Purpose : DEPTH-stage shadow pipeline for instruction words / PCs. Stage 0 is
//           the youngest, stage DEPTH-1 the oldest. Each stage can be held or
//           flushed; holding a stage also holds every younger stage, and the
//           first stage below a held region receives a bubble. A registered
//           occupancy count tracks the number of valid stages.
//
// Ports   : i_clk         clock, rising edge
//           i_reset       asynchronous active-high reset
//           i_enable      global advance gate; low freezes all state
//           i_valid       valid bit of the incoming word
//           i_data        incoming word, captured into stage 0
//           i_hold        per-stage hold request (bit k = stage k)
//           i_flush       per-stage flush request (bit k = stage k)
//           o_data        all stage words, slice [k*DATA_W +: DATA_W] = stage k
//           o_valid       per-stage valid bits
//           o_last_data   oldest stage word
//           o_last_valid  oldest stage valid
//           o_count       number of valid stages (registered)
// -----------------------------------------------------------------------------
module pipe_delay_line
  import common_pkg::*;
#(
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       DEPTH      = 3,
  parameter logic [DATA_W-1:0] RESET_VAL  = '0,
  parameter logic [31:0]       BUBBLE_VAL = RV_NOP
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_enable,
  input  logic                       i_valid,
  input  logic [DATA_W-1:0]          i_data,
  input  logic [DEPTH-1:0]           i_hold,
  input  logic [DEPTH-1:0]           i_flush,
  output logic [DEPTH*DATA_W-1:0]    o_data,
  output logic [DEPTH-1:0]           o_valid,
  output logic [DATA_W-1:0]          o_last_data,
  output logic                       o_last_valid,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  // Bubble word fitted to the data width (truncate or zero-extend).
  localparam logic [DATA_W-1:0] BUBBLE_W = DATA_W'(BUBBLE_VAL);

  if (DEPTH < 1) begin : g_depth_check
    $error("pipe_delay_line: DEPTH must be >= 1");
  end

  logic [DATA_W-1:0] stage_data [DEPTH];
  logic [DATA_W-1:0] prev_data  [DEPTH];
  logic [DEPTH-1:0]  prev_valid;
  logic [DEPTH-1:0]  stage_valid;
  logic [DEPTH-1:0]  valid_d;
  logic [DEPTH-1:0]  h_eff;
  logic [DEPTH-1:0]  bubble;

  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;

  // Effective hold: a stall at stage k freezes every younger stage as well,
  // so h_eff[k] is the OR of i_hold[k..DEPTH-1], built from the oldest end.
  assign h_eff[DEPTH-1] = i_hold[DEPTH-1];

  genvar gi;
  for (gi = 0; gi < DEPTH - 1; gi++) begin : g_heff
    assign h_eff[gi] = i_hold[gi] | h_eff[gi + 1];
  end

  // Stage input selection and bubble control. Stage 0 is fed from the line
  // input and never sees a bubble (there is nothing younger to be held).
  for (gi = 0; gi < DEPTH; gi++) begin : g_link
    if (gi == 0) begin : g_head
      assign prev_data[gi]  = i_data;
      assign prev_valid[gi] = i_valid;
      assign bubble[gi]     = 1'b0;
    end else begin : g_body
      assign prev_data[gi]  = stage_data[gi - 1];
      assign prev_valid[gi] = stage_valid[gi - 1];
      assign bubble[gi]     = h_eff[gi - 1];
    end
  end

  for (gi = 0; gi < DEPTH; gi++) begin : g_stage
    pipe_stage #(
      .DATA_W     (DATA_W),
      .RESET_VAL  (RESET_VAL),
      .BUBBLE_VAL (BUBBLE_W)
    ) u_stage (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_enable     (i_enable),
      .i_prev_data  (prev_data[gi]),
      .i_prev_valid (prev_valid[gi]),
      .i_flush      (i_flush[gi]),
      .i_hold       (h_eff[gi]),
      .i_bubble     (bubble[gi]),
      .o_data       (stage_data[gi]),
      .o_valid      (stage_valid[gi]),
      .o_valid_d    (valid_d[gi])
    );

    assign o_data[gi*DATA_W +: DATA_W] = stage_data[gi];
  end

  // Count is taken from the next-state valid bits so the registered value
  // matches o_valid in the same cycle.
  always_comb begin
    count_d = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      count_d = count_d + CNT_W'(valid_d[k]);
    end
    if (!i_enable) begin
      count_d = count_q;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_valid      = stage_valid;
  assign o_last_data  = stage_data[DEPTH-1];
  assign o_last_valid = stage_valid[DEPTH-1];
  assign o_count      = count_q;

endmodule : pipe_delay_line
